// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the two requester byte streams and the UART TX fifo write port
//   that the arbiter sits between.
//
//   master : the environment side (requesters drive valid/data/last, fifo
//            drives full; sees ready, wr and w_data)
//   slave  : the arbiter side
//
//   Signals
//     reqN_valid  requester N has a byte
//     reqN_data   requester N byte (B bits)
//     reqN_last   byte is the final byte of its packet
//     reqN_ready  byte accepted this cycle when valid & ready
//     fifo_full   fifo full flag (registered inside the fifo)
//     fifo_wr     fifo write strobe
//     fifo_w_data fifo write data (B bits)
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int B = 8
);
    logic         req0_valid;
    logic [B-1:0] req0_data;
    logic         req0_last;
    logic         req0_ready;
    logic         req1_valid;
    logic [B-1:0] req1_data;
    logic         req1_last;
    logic         req1_ready;
    logic         fifo_full;
    logic         fifo_wr;
    logic [B-1:0] fifo_w_data;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output fifo_full,
        input  req0_ready, req1_ready,
        input  fifo_wr, fifo_w_data
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  fifo_full,
        output req0_ready, req1_ready,
        output fifo_wr, fifo_w_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares the write port of the UART TX fifo between two byte-stream
//   requesters. Grants are round-robin at packet granularity: the owner keeps
//   the fifo until it sends a byte flagged 'last' or stays silent for IDLE_TO
//   cycles, in which case the grant is revoked and timeout_tick pulses.
//
//   Parameters
//     B        data word width (matches the fifo)
//     TO_W     width of the idle-timeout counter
//     IDLE_TO  silent owner cycles before revocation, 1 <= IDLE_TO < 2**TO_W
//
//   Ports
//     clk          clock, all state on the rising edge
//     reset        asynchronous, active-high
//     bus          requester/fifo handshake bundle (slave side)
//     grant        one-hot current owner, 2'b00 when idle
//     busy         a packet is in progress
//     timeout_tick one-cycle pulse in the first IDLE cycle after a timeout
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int B       = 8,
    parameter int TO_W    = 8,
    parameter int IDLE_TO = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.slave     bus,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 timeout_tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Counter value seen on the last silent cycle before revocation.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TO - 1);

    state_t         state;
    logic           prio;
    logic [TO_W-1:0] idle_cnt;

    logic own0;
    logic own1;
    logic xfer0;
    logic xfer1;
    logic cur_xfer;
    logic cur_valid;
    logic cur_last;

    // Handshake decode. Only the current owner can ever be ready, and only
    // while the fifo has room, so a write never lands on a full fifo and the
    // two requesters can never both see ready. The write data follows the
    // owner so the fifo sees a stable value during a stall, and is forced to
    // zero while idle.
    assign own0     = (state == OWN0);
    assign own1     = (state == OWN1);
    assign bus.req0_ready = own0 & ~bus.fifo_full;
    assign bus.req1_ready = own1 & ~bus.fifo_full;
    assign xfer0    = bus.req0_valid & bus.req0_ready;
    assign xfer1    = bus.req1_valid & bus.req1_ready;
    assign cur_xfer = xfer0 | xfer1;
    assign bus.fifo_wr = cur_xfer;
    assign bus.fifo_w_data = own0 ? bus.req0_data :
                             own1 ? bus.req1_data : '0;

    // The owner's view of its own stream, so OWN0 and OWN1 share one branch.
    assign cur_valid = own0 ? bus.req0_valid : bus.req1_valid;
    assign cur_last  = own0 ? bus.req0_last  : bus.req1_last;

    // Arbitration FSM. In IDLE a single requester wins outright and a tie goes
    // to prio. While owning, a transfer restarts the silence count and a
    // 'last' transfer releases the fifo; a cycle with valid low counts as
    // silence, whereas a full-fifo stall does not. Every release hands prio
    // to the other requester and passes through IDLE, which is what gives the
    // one-cycle bubble between packets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prio         <= 1'b0;
            idle_cnt     <= '0;
            grant        <= 2'b00;
            busy         <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            timeout_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (bus.req0_valid && (!bus.req1_valid || !prio)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                        busy  <= 1'b1;
                    end else if (bus.req1_valid) begin
                        state <= OWN1;
                        grant <= 2'b10;
                        busy  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (cur_xfer) begin
                        idle_cnt <= '0;
                        if (cur_last) begin
                            state <= IDLE;
                            grant <= 2'b00;
                            busy  <= 1'b0;
                            prio  <= own0;
                        end
                    end else if (!cur_valid) begin
                        if (idle_cnt == TO_LAST) begin
                            state        <= IDLE;
                            grant        <= 2'b00;
                            busy         <= 1'b0;
                            prio         <= own0;
                            idle_cnt     <= '0;
                            timeout_tick <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= 2'b00;
                    busy     <= 1'b0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed scenarios for the UART TX arbiter (IDLE_TO = 4) followed by a
//   randomised soak with a per-requester byte-order scoreboard.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int B       = 8;
    localparam int TO_W    = 8;
    localparam int IDLE_TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_tick;

    int vecs = 0;
    int errs = 0;

    uart_tx_arbiter_if #(.B(B)) bus ();

    uart_tx_arbiter #(
        .B       (B),
        .TO_W    (TO_W),
        .IDLE_TO (IDLE_TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .grant        (grant),
        .busy         (busy),
        .timeout_tick (timeout_tick)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Packs every observable output into one word for compact comparisons.
    function automatic logic [14:0] obs();
        return {grant, busy, bus.req0_ready, bus.req1_ready, bus.fifo_wr,
                timeout_tick, bus.fifo_w_data};
    endfunction

    // Builds the expected word; busy is simply "someone owns the fifo".
    function automatic logic [14:0] exp_v(input logic [1:0] g, input logic r0,
                                          input logic r1, input logic wr,
                                          input logic to, input logic [7:0] d);
        return {g, |g, r0, r1, wr, to, d};
    endfunction

    // Advances to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.req1_last  = 1'b0;
        bus.fifo_full  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Outputs stay at reset values while reset is held, even with both
    // requesters asking, and nothing is granted while the inputs stay quiet.
    task automatic test_reset();
        logic [14:0] e;
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h5C;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h3E;
        e = exp_v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if (obs() !== e) begin
                errs++;
                $display("[TB] FAIL reset_hold k=%0d got=%h want=%h", k, obs(), e);
            end
        end
        idle_inputs();
        #1;
        reset = 1'b0;
        tick();
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL reset_release got=%h want=%h", obs(), e);
        end
    endtask

    // One 3-byte packet from req0, then a 1-byte packet showing the bubble.
    task automatic test_single_packet();
        logic [14:0] e;
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA1;
        #1;
        e = exp_v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_idle got=%h want=%h", obs(), e);
        end
        tick();
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_byte1 got=%h want=%h", obs(), e);
        end
        tick();
        bus.req0_data = 8'hA2;
        #1;
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA2);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_byte2 got=%h want=%h", obs(), e);
        end
        tick();
        bus.req0_data = 8'hA3;
        bus.req0_last = 1'b1;
        #1;
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA3);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_byte3 got=%h want=%h", obs(), e);
        end
        tick();
        bus.req0_data = 8'hB1;
        #1;
        e = exp_v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_bubble got=%h want=%h", obs(), e);
        end
        tick();
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB1);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_regrant got=%h want=%h", obs(), e);
        end
        tick();
        idle_inputs();
        #1;
        e = exp_v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL pkt_done got=%h want=%h", obs(), e);
        end
    endtask

    // Both requesters permanently asking with 1-byte packets: 0,1,0,1.
    task automatic test_round_robin();
        logic [1:0]  g_tab [8];
        logic [1:0]  g;
        logic [7:0]  d;
        logic [14:0] e;
        g_tab = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h10;
        bus.req0_last  = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h20;
        bus.req1_last  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            g = g_tab[k];
            d = (g == 2'b01) ? 8'h10 : (g == 2'b10) ? 8'h20 : 8'h00;
            e = exp_v(g, g == 2'b01, g == 2'b10, g != 2'b00, 1'b0, d);
            vecs++;
            if (obs() !== e) begin
                errs++;
                $display("[TB] FAIL rr k=%0d got=%h want=%h", k, obs(), e);
            end
            @(posedge clk);
        end
        #1;
        idle_inputs();
    endtask

    // Fifo full for 5 owner cycles: no write, no ready, no timeout.
    task automatic test_full_stall();
        logic [14:0] e;
        apply_reset();
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h5A;
        bus.fifo_full  = 1'b1;
        tick();
        e = exp_v(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (obs() !== e) begin
                errs++;
                $display("[TB] FAIL stall k=%0d got=%h want=%h", k, obs(), e);
            end
            tick();
        end
        bus.fifo_full = 1'b0;
        #1;
        e = exp_v(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL stall_release got=%h want=%h", obs(), e);
        end
        tick();
        idle_inputs();
        #1;
        e = exp_v(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL stall_after got=%h want=%h", obs(), e);
        end
        apply_reset();
    endtask

    // One byte from req0 then silence: revoked after exactly 4 idle cycles,
    // then pending req1 takes over.
    task automatic test_timeout();
        logic [14:0] e;
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h33;
        tick();
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL to_byte got=%h want=%h", obs(), e);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h44;
        bus.req1_last  = 1'b1;
        #1;
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            vecs++;
            if (obs() !== e) begin
                errs++;
                $display("[TB] FAIL to_wait k=%0d got=%h want=%h", k, obs(), e);
            end
            tick();
        end
        e = exp_v(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL to_tick got=%h want=%h", obs(), e);
        end
        tick();
        e = exp_v(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL to_next got=%h want=%h", obs(), e);
        end
        apply_reset();
    endtask

    // Reset asserted mid-packet clears outputs at once; afterwards a tie
    // goes to req0 again.
    task automatic test_reset_mid_packet();
        logic [14:0] e;
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h01;
        bus.req0_last  = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h11;
        tick();
        tick();
        bus.req0_data = 8'h02;
        bus.req0_last = 1'b0;
        tick();
        e = exp_v(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL rst_own1 got=%h want=%h", obs(), e);
        end
        tick();
        bus.req1_data = 8'h12;
        tick();
        bus.req1_data = 8'h13;
        #1;
        reset = 1'b1;
        #1;
        e = exp_v(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL rst_async got=%h want=%h", obs(), e);
        end
        tick();
        #2;
        reset = 1'b0;
        tick();
        e = exp_v(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("[TB] FAIL rst_regrant got=%h want=%h", obs(), e);
        end
        apply_reset();
    endtask

    // Random soak. Each requester numbers its bytes, so the fifo stream must
    // show each requester's numbers in order, and one packet's bytes must not
    // be interleaved with the other requester's until 'last' or a timeout.
    task automatic test_random();
        logic       pend [2];
        logic [7:0] dat  [2];
        logic       lst  [2];
        logic [6:0] seq  [2];
        logic [6:0] nxt  [2];
        logic       v    [2];
        logic       hs0;
        logic       hs1;
        int         w;
        int         owner;
        logic [7:0] want;
        apply_reset();
        owner = -1;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0;
            dat[i]  = '0;
            lst[i]  = 1'b0;
            seq[i]  = '0;
            nxt[i]  = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = {i[0], seq[i]};
                    lst[i]  = ($urandom_range(0, 3) == 0);
                    seq[i]  = seq[i] + 1'b1;
                end
                v[i] = pend[i] && ($urandom_range(0, 9) != 0);
            end
            bus.req0_valid = v[0];
            bus.req0_data  = v[0] ? dat[0] : 8'($urandom);
            bus.req0_last  = v[0] ? lst[0] : 1'($urandom);
            bus.req1_valid = v[1];
            bus.req1_data  = v[1] ? dat[1] : 8'($urandom);
            bus.req1_last  = v[1] ? lst[1] : 1'($urandom);
            bus.fifo_full  = ($urandom_range(0, 3) == 0);
            #1;
            hs0 = bus.req0_valid & bus.req0_ready;
            hs1 = bus.req1_valid & bus.req1_ready;
            vecs++;
            if ((bus.fifo_wr && bus.fifo_full) ||
                (bus.req0_ready && bus.req1_ready) ||
                (bus.req0_ready && !grant[0]) ||
                (bus.req1_ready && !grant[1]) ||
                (grant == 2'b11)) begin
                errs++;
                $display("[TB] FAIL rnd_protocol c=%0d wr=%b full=%b rdy=%b%b grant=%b",
                         c, bus.fifo_wr, bus.fifo_full, bus.req1_ready,
                         bus.req0_ready, grant);
            end
            vecs++;
            if (bus.fifo_wr !== (hs0 | hs1)) begin
                errs++;
                $display("[TB] FAIL rnd_wr c=%0d got=%b want=%b", c, bus.fifo_wr, hs0 | hs1);
            end
            if (timeout_tick) owner = -1;
            if (hs0 | hs1) begin
                w    = hs0 ? 0 : 1;
                want = {w[0], nxt[w]};
                vecs++;
                if (bus.fifo_w_data !== want) begin
                    errs++;
                    $display("[TB] FAIL rnd_data c=%0d got=%h want=%h", c, bus.fifo_w_data, want);
                end
                vecs++;
                if (owner != -1 && owner != w) begin
                    errs++;
                    $display("[TB] FAIL rnd_interleave c=%0d got=req%0d want=req%0d", c, w, owner);
                end
                nxt[w] = nxt[w] + 1'b1;
                owner  = lst[w] ? -1 : w;
            end
            tick();
            if (hs0) pend[0] = 1'b0;
            if (hs1) pend[1] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
